// File: rtl/debug_step_ctrl_pkg.sv
// rtl/debug_step_ctrl_pkg.sv - states, default phase lengths and host endpoint map for debug_step_ctrl
package debug_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2,
        ST_CHECK = 2'd3
    } step_state_e;

    localparam int DEF_STEP_HI_CYCLES = 4;
    localparam int DEF_STEP_LO_CYCLES = 4;

    // Host wire-out endpoints for progress readback
    localparam logic [7:0] EP_STEPS_DONE_LO = 8'h24;
    localparam logic [7:0] EP_STEPS_DONE_HI = 8'h25;
    localparam logic [7:0] EP_STATUS        = 8'h26;

    function automatic int timer_width(input int hi_cycles, input int lo_cycles);
        int longest;
        longest = (hi_cycles > lo_cycles) ? hi_cycles : lo_cycles;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/debug_step_ctrl_if.sv
// rtl/debug_step_ctrl_if.sv - host request / debug unit signal bundle for debug_step_ctrl
interface debug_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             debug_enable;
    logic             step_req;
    logic             run_req;
    logic             halt_req;
    logic [CNT_W-1:0] step_count;
    logic [7:0]       break_addr;
    logic             break_en;
    logic [7:0]       clock_counter;
    logic             single_step;
    logic             busy;
    logic             done;
    logic             break_hit;
    logic [CNT_W-1:0] steps_done;

    modport master (
        output debug_enable, step_req, run_req, halt_req, step_count,
               break_addr, break_en, clock_counter,
        input  single_step, busy, done, break_hit, steps_done
    );

    modport slave (
        input  debug_enable, step_req, run_req, halt_req, step_count,
               break_addr, break_en, clock_counter,
        output single_step, busy, done, break_hit, steps_done
    );

endinterface

// File: rtl/debug_step_timer.sv
// rtl/debug_step_timer.sv - loadable down-counter; expired_o marks the last cycle of a HI/LO phase
module debug_step_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/debug_step_ctrl.sv
// rtl/debug_step_ctrl.sv - host single-step sequencer for the debug clock gate
// Breakpoint compare and break_hit exist only when DEBUG_STEP_BREAK_EN is defined.
module debug_step_ctrl
    import debug_step_ctrl_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int STEP_HI_CYCLES = DEF_STEP_HI_CYCLES,
    parameter int STEP_LO_CYCLES = DEF_STEP_LO_CYCLES
) (
    input  logic             sys_clk_ext,
    input  logic             reset_n,
    debug_step_ctrl_if.slave dbg
);

    localparam int TMR_W = timer_width(STEP_HI_CYCLES, STEP_LO_CYCLES);

    // LO must outlast the debug unit's 2-cycle gated-edge latency plus re-arm
    if (STEP_HI_CYCLES < 1) begin : g_hi_chk
        $error("STEP_HI_CYCLES must be at least 1");
    end
    if (STEP_LO_CYCLES < 3) begin : g_lo_chk
        $error("STEP_LO_CYCLES must be at least 3");
    end

    step_state_e      state_q, state_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q, run_d;
    logic             brk_en_q, brk_en_d;
    logic             halt_q, halt_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_exp;
    logic             brk_match;
    logic             enter_hi;
    logic             end_seq;

    debug_step_timer #(.W(TMR_W)) u_timer (
        .clk        (sys_clk_ext),
        .rst_n      (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

`ifdef DEBUG_STEP_BREAK_EN
    assign brk_match = brk_en_q && (dbg.clock_counter == dbg.break_addr);
`else
    logic unused_break;
    assign brk_match    = 1'b0;
    assign unused_break = ^{dbg.break_addr, dbg.clock_counter, brk_en_q};
`endif

    always_ff @(posedge sys_clk_ext or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            steps_q  <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
            brk_en_q <= 1'b0;
            halt_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            steps_q  <= steps_d;
            count_q  <= count_d;
            run_q    <= run_d;
            brk_en_q <= brk_en_d;
            halt_q   <= halt_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        steps_d  = steps_q;
        count_d  = count_q;
        run_d    = run_q;
        brk_en_d = brk_en_q;
        halt_d   = halt_q;
        done_d   = 1'b0;
        hit_d    = hit_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        enter_hi = 1'b0;
        end_seq  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dbg.debug_enable && !dbg.halt_req) begin
                    if (dbg.step_req) begin
                        steps_d = '0;
                        if (dbg.step_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            hit_d    = 1'b0;
                            count_d  = dbg.step_count;
                            run_d    = 1'b0;
                            brk_en_d = dbg.break_en;
                            enter_hi = 1'b1;
                        end
                    end else if (dbg.run_req) begin
                        steps_d  = '0;
                        hit_d    = 1'b0;
                        run_d    = 1'b1;
                        brk_en_d = dbg.break_en;
                        enter_hi = 1'b1;
                    end
                end
            end
            ST_HI: begin
                if (dbg.halt_req) halt_d = 1'b1;
                if (tmr_exp) begin
                    state_d  = ST_LO;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(STEP_LO_CYCLES - 1);
                end
            end
            ST_LO: begin
                if (dbg.halt_req) halt_d = 1'b1;
                if (tmr_exp) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (brk_match) begin
                    hit_d   = 1'b1;
                    end_seq = 1'b1;
                end else if (halt_q || dbg.halt_req) begin
                    end_seq = 1'b1;
                end else if (!run_q && (steps_q == count_q)) begin
                    end_seq = 1'b1;
                end else begin
                    enter_hi = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_hi) begin
            state_d  = ST_HI;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STEP_HI_CYCLES - 1);
            if (steps_d != '1) steps_d = steps_d + CNT_W'(1);
        end

        if (end_seq) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
        end

        // Losing debug_enable mid-sequence drops the step level at once
        if ((state_q != ST_IDLE) && !dbg.debug_enable) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            halt_d   = 1'b0;
            steps_d  = steps_q;
            hit_d    = hit_q;
            tmr_load = 1'b0;
        end
    end

    assign dbg.single_step = (state_q == ST_HI);
    assign dbg.busy        = (state_q != ST_IDLE);
    assign dbg.done        = done_q;
    assign dbg.break_hit   = hit_q;
    assign dbg.steps_done  = steps_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// tb/tb_debug_step_ctrl.sv - directed self-checking bench for debug_step_ctrl
module tb_debug_step_ctrl;

`ifdef DEBUG_STEP_BREAK_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_step_ctrl_if #(.CNT_W(16)) dif ();

    debug_step_ctrl #(
        .CNT_W          (16),
        .STEP_HI_CYCLES (4),
        .STEP_LO_CYCLES (4)
    ) dut (
        .sys_clk_ext (clk),
        .reset_n     (rst_n),
        .dbg         (dif.slave)
    );

    // Debug unit model: gated edge two cycles after single_step rises
    logic       ss_d1 = 1'b0;
    logic       ss_d2 = 1'b0;
    logic       cc_load = 1'b1;
    logic [7:0] cc_val = 8'h00;

    always @(posedge clk) begin
        ss_d1 <= dif.single_step;
        ss_d2 <= ss_d1;
        if (cc_load) dif.clock_counter <= cc_val;
        else if (ss_d1 && !ss_d2) dif.clock_counter <= dif.clock_counter + 8'd1;
    end

    int   tests = 0;
    int   fails = 0;
    int   busy_cyc, hi_cyc, rise_cnt, done_cnt;
    logic ss_prev;
    logic [7:0] cc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (dif.busy === 1'b1) busy_cyc++;
            if (dif.done === 1'b1) done_cnt++;
            if (dif.single_step === 1'b1) hi_cyc++;
            if (dif.single_step === 1'b1 && ss_prev !== 1'b1) rise_cnt++;
            ss_prev = dif.single_step;
        end
    endtask

    task automatic clr_mon();
        busy_cyc = 0;
        hi_cyc   = 0;
        rise_cnt = 0;
        done_cnt = 0;
        ss_prev  = dif.single_step;
    endtask

    initial begin
        rst_n            = 1'b1;
        dif.debug_enable = 1'b1;
        dif.step_req     = 1'b0;
        dif.run_req      = 1'b0;
        dif.halt_req     = 1'b0;
        dif.step_count   = '0;
        dif.break_addr   = 8'h00;
        dif.break_en     = 1'b0;
        clr_mon();
        #3 rst_n = 1'b0;
        tick(2);
        check("rst_single_step", 32'(dif.single_step), 32'd0);
        check("rst_busy",        32'(dif.busy),        32'd0);
        check("rst_done",        32'(dif.done),        32'd0);
        check("rst_break_hit",   32'(dif.break_hit),   32'd0);
        check("rst_steps_done",  32'(dif.steps_done),  32'd0);
        rst_n   = 1'b1;
        cc_load = 1'b0;
        tick(1);

        // Three steps with default phase lengths
        clr_mon();
        cc0 = dif.clock_counter;
        dif.step_count = 16'd3;
        dif.step_req   = 1'b1;
        tick(1);
        dif.step_req = 1'b0;
        check("t1_first_ss",   32'(dif.single_step), 32'd1);
        check("t1_first_busy", 32'(dif.busy),        32'd1);
        tick(26);
        check("t1_last_busy",  32'(dif.busy), 32'd1);
        tick(1);
        check("t1_busy_fall",  32'(dif.busy), 32'd0);
        check("t1_done_pulse", 32'(dif.done), 32'd1);
        tick(1);
        check("t1_done_clear", 32'(dif.done), 32'd0);
        check("t1_busy_cyc",   32'(busy_cyc), 32'd27);
        check("t1_rises",      32'(rise_cnt), 32'd3);
        check("t1_hi_cyc",     32'(hi_cyc),   32'd12);
        check("t1_done_cnt",   32'(done_cnt), 32'd1);
        check("t1_steps_done", 32'(dif.steps_done), 32'd3);
        check("t1_cc_advance", 32'(dif.clock_counter - cc0), 32'd3);

        // Zero count: done only
        clr_mon();
        dif.step_count = 16'd0;
        dif.step_req   = 1'b1;
        tick(1);
        dif.step_req = 1'b0;
        check("t2_done",       32'(dif.done),       32'd1);
        check("t2_busy",       32'(dif.busy),       32'd0);
        check("t2_ss",         32'(dif.single_step), 32'd0);
        check("t2_steps_done", 32'(dif.steps_done), 32'd0);
        tick(2);
        check("t2_busy_cyc",   32'(busy_cyc), 32'd0);
        check("t2_done_cnt",   32'(done_cnt), 32'd1);

        // Halt together with a request in IDLE discards the request
        clr_mon();
        dif.step_count = 16'd2;
        dif.step_req   = 1'b1;
        dif.halt_req   = 1'b1;
        tick(1);
        dif.step_req = 1'b0;
        dif.halt_req = 1'b0;
        tick(2);
        check("t2b_busy_cyc", 32'(busy_cyc), 32'd0);
        check("t2b_done_cnt", 32'(done_cnt), 32'd0);

        // Run mode with breakpoint at 0x05, counter preset to 0x02
        cc_val  = 8'h02;
        cc_load = 1'b1;
        tick(1);
        cc_load = 1'b0;
        clr_mon();
        dif.break_en   = 1'b1;
        dif.break_addr = 8'h05;
        dif.run_req    = 1'b1;
        tick(1);
        dif.run_req  = 1'b0;
        dif.break_en = 1'b0;
        tick(29);
        dif.halt_req = 1'b1;
        tick(1);
        dif.halt_req = 1'b0;
        tick(11);
        check("t3_busy_cyc",   32'(busy_cyc), BRK ? 32'd27 : 32'd36);
        check("t3_done_cnt",   32'(done_cnt), 32'd1);
        check("t3_steps_done", 32'(dif.steps_done), BRK ? 32'd3 : 32'd4);
        check("t3_break_hit",  32'(dif.break_hit), BRK ? 32'd1 : 32'd0);
        check("t3_busy_end",   32'(dif.busy), 32'd0);
        check("t3_cc",         32'(dif.clock_counter), BRK ? 32'h05 : 32'h06);

        // Run mode, halt mid-HI: full pulse and LO, then stop
        clr_mon();
        dif.run_req = 1'b1;
        tick(1);
        dif.run_req = 1'b0;
        tick(1);
        dif.halt_req = 1'b1;
        tick(1);
        dif.halt_req = 1'b0;
        tick(12);
        check("t4_hi_cyc",     32'(hi_cyc),   32'd4);
        check("t4_rises",      32'(rise_cnt), 32'd1);
        check("t4_busy_cyc",   32'(busy_cyc), 32'd9);
        check("t4_done_cnt",   32'(done_cnt), 32'd1);
        check("t4_steps_done", 32'(dif.steps_done), 32'd1);
        check("t4_break_hit",  32'(dif.break_hit), 32'd0);

        // debug_enable dropped in HI of step 2 of 5
        clr_mon();
        dif.step_count = 16'd5;
        dif.step_req   = 1'b1;
        tick(1);
        dif.step_req = 1'b0;
        tick(10);
        check("t5_ss_before", 32'(dif.single_step), 32'd1);
        dif.debug_enable = 1'b0;
        tick(1);
        check("t5_ss",         32'(dif.single_step), 32'd0);
        check("t5_busy",       32'(dif.busy),        32'd0);
        check("t5_done",       32'(dif.done),        32'd1);
        check("t5_steps_done", 32'(dif.steps_done),  32'd2);
        check("t5_break_hit",  32'(dif.break_hit),   32'd0);
        dif.debug_enable = 1'b1;
        tick(1);
        check("t5_done_clear", 32'(dif.done), 32'd0);

        // Asynchronous reset mid-sequence, then a single step
        clr_mon();
        dif.step_count = 16'd3;
        dif.step_req   = 1'b1;
        tick(1);
        dif.step_req = 1'b0;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ss",         32'(dif.single_step), 32'd0);
        check("t6_rst_busy",       32'(dif.busy),        32'd0);
        check("t6_rst_steps_done", 32'(dif.steps_done),  32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        clr_mon();
        dif.step_count = 16'd1;
        dif.step_req   = 1'b1;
        tick(1);
        dif.step_req = 1'b0;
        tick(11);
        check("t6_rises",      32'(rise_cnt), 32'd1);
        check("t6_hi_cyc",     32'(hi_cyc),   32'd4);
        check("t6_busy_cyc",   32'(busy_cyc), 32'd9);
        check("t6_done_cnt",   32'(done_cnt), 32'd1);
        check("t6_steps_done", 32'(dif.steps_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
